// File: rtl/reconfig_chk_pkg.sv
// Shared types and constants for the reconfigurable-partition shift-pattern checker.
// Also carries the next-word prediction as a macro so any width can use it.
`ifndef RECONFIG_CHK_PRED
  `define RECONFIG_CHK_PRED(p, w) {p[(w)-2:0], ~p[0]}
`endif

package reconfig_chk_pkg;
  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int RUN_W = 8;
endpackage

// File: rtl/reconfig_chk_satcnt.sv
// Saturating up-counter with synchronous clear; parks at all-ones instead of wrapping.
module reconfig_chk_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)                 q <= '0;
    else if (clr)            q <= '0;
    else if (inc && ~&q)     q <= q + W'(1);
  end
endmodule

// File: rtl/reconfig_checker.sv
// Receive-side checker for the alternating-insert shift pattern: lock, error pulse, sticky loss.
// Define RECONFIG_CHK_ERRCNT_EN to build the saturating err_cnt; otherwise err_cnt is tied to 0.
module reconfig_checker
  import reconfig_chk_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int LOCK_N = 4,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] data,
  output logic              locked,
  output logic              err,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam logic [RUN_W-1:0] LOCK_C = RUN_W'(LOCK_N);
  localparam logic [RUN_W-1:0] LOSS_C = RUN_W'(LOSS_N);
  localparam logic [RUN_W-1:0] ONE    = RUN_W'(1);

  logic [DATA_W-1:0] data_q, prev, pred;
  logic              hist_v, match;
  state_t            state, state_n;
  logic [RUN_W-1:0]  run, run_n, miss, miss_n;
  logic              err_n, drop;

  assign pred  = `RECONFIG_CHK_PRED(prev, DATA_W);
  assign match = hist_v && (data_q == pred);

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q    <= '0;
      prev      <= '0;
      hist_v    <= 1'b0;
      state     <= ST_SEARCH;
      run       <= '0;
      miss      <= '0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      data_q <= data;
      prev   <= data_q;
      hist_v <= en;
      state  <= state_n;
      run    <= run_n;
      miss   <= miss_n;
      err    <= err_n;
      // clr beats a simultaneous loss of lock
      if (clr)       lock_lost <= 1'b0;
      else if (drop) lock_lost <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    miss_n  = miss;
    err_n   = 1'b0;
    drop    = 1'b0;
    if (!en) begin
      state_n = ST_SEARCH;
      run_n   = '0;
      miss_n  = '0;
    end else if (state == ST_SEARCH) begin
      if (!match)                  run_n = '0;
      else if (run + ONE == LOCK_C) begin
        state_n = ST_LOCKED;
        run_n   = '0;
        miss_n  = '0;
      end else                     run_n = run + ONE;
    end else begin
      if (match)                   miss_n = '0;
      else begin
        err_n = 1'b1;
        if (miss + ONE == LOSS_C) begin
          state_n = ST_SEARCH;
          run_n   = '0;
          miss_n  = '0;
          drop    = 1'b1;
        end else                   miss_n = miss + ONE;
      end
    end
  end

  always_comb locked = (state == ST_LOCKED);

`ifdef RECONFIG_CHK_ERRCNT_EN
  reconfig_chk_satcnt #(.W(CNT_W)) u_err_cnt (
    .clk (CLK),
    .rst (RST),
    .inc (err_n),
    .clr (clr),
    .q   (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_reconfig_checker.sv
// Bench for reconfig_checker: hand-traced vector table plus a generator-driven saturation run.
module tb_reconfig_checker;
  logic       CLK = 1'b0;
  logic       RST = 1'b1, en = 1'b0, clr = 1'b0;
  logic [3:0] data = '0;
  logic       locked, err, lock_lost;
  logic [15:0] err_cnt;
  logic       locked4, err4, lock_lost4;
  logic [3:0] err_cnt4;

  always #5 CLK = ~CLK;

  reconfig_checker dut (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr), .data(data),
    .locked(locked), .err(err), .lock_lost(lock_lost), .err_cnt(err_cnt)
  );

  reconfig_checker #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .en(en), .clr(clr), .data(data),
    .locked(locked4), .err(err4), .lock_lost(lock_lost4), .err_cnt(err_cnt4)
  );

  typedef struct {
    logic       r, e, c;
    logic [3:0] d;
    logic       lk, er, ll;
    int         n;
  } vec_t;

  typedef struct {
    logic lk, er, ll;
    int   n;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic int exp_cnt(input int n, input int w);
`ifdef RECONFIG_CHK_ERRCNT_EN
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  function automatic logic [3:0] gen_next(input logic [3:0] w);
    return {w[2:0], ~w[0]};
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0d want %0d", nm, vectors, act, req);
    end
  endtask

  task automatic add(input logic r, e, c, input logic [3:0] d,
                     input logic lk, er, ll, input int n);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.d = d;
    v.lk = lk; v.er = er; v.ll = ll; v.n = n;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, e, c, input logic [3:0] d,
                      input logic lk, er, ll, input int n);
    exp_t x, g;
    @(negedge CLK);
    RST = r; en = e; clr = c; data = d;
    x.lk = lk; x.er = er; x.ll = ll; x.n = n;
    sbq.push_back(x);
    @(posedge CLK);
    #1;
    g = sbq.pop_front();
    vectors++;
    chk("locked",     int'(locked),     int'(g.lk));
    chk("err",        int'(err),        int'(g.er));
    chk("lock_lost",  int'(lock_lost),  int'(g.ll));
    chk("err_cnt",    int'(err_cnt),    exp_cnt(g.n, 16));
    chk("locked4",    int'(locked4),    int'(g.lk));
    chk("lock_lost4", int'(lock_lost4), int'(g.ll));
    chk("err_cnt4",   int'(err_cnt4),   exp_cnt(g.n, 4));
  endtask

  initial begin
    logic [3:0] g;
    int   n;
    logic lost, c, lk, er;

    //  r  e  c  data     lk er ll n
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0);
    // fill phase, then pattern: lock one edge after 1010 lands in data_q
    add(0, 1, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0010, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0101, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1010, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0101, 1, 0, 0, 0);
    add(0, 1, 0, 4'b1010, 1, 0, 0, 0);
    // single corrupted word -> two mispredictions, loss of lock, relock
    add(0, 1, 0, 4'b0111, 1, 0, 0, 0);
    add(0, 1, 0, 4'b1010, 1, 1, 0, 1);
    add(0, 1, 0, 4'b0101, 0, 1, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 1, 0, 1, 2);
    add(0, 1, 1, 4'b1010, 1, 0, 0, 0);
    // stuck word
    add(0, 1, 0, 4'b1010, 1, 0, 0, 0);
    add(0, 1, 0, 4'b1010, 1, 1, 0, 1);
    add(0, 1, 0, 4'b1010, 0, 1, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 1, 0, 1, 2);
    // en low for three cycles, relock five edges after en returns
    add(0, 0, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 0, 0, 4'b0101, 0, 0, 1, 2);
    add(0, 0, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1010, 0, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 1, 0, 1, 2);
    // reset with a mismatch still in the pipe
    add(0, 1, 0, 4'b0111, 1, 0, 1, 2);
    add(0, 1, 0, 4'b0101, 1, 1, 1, 3);
    add(1, 1, 0, 4'b1010, 0, 0, 0, 0);
    add(1, 0, 0, 4'b0000, 0, 0, 0, 0);

    foreach (tbl[i])
      step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].d,
           tbl[i].lk, tbl[i].er, tbl[i].ll, tbl[i].n);

    // generator-driven lock, then repeated single-word corruption to saturate the 4-bit count
    g = 4'b0000;
    step(0, 1, 0, g, 0, 0, 0, 0);
    step(0, 1, 0, g, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      g = gen_next(g);
      step(0, 1, 0, g, (k == 4), 0, 0, 0);
    end

    n = 0;
    lost = 1'b0;
    for (int rep = 0; rep < 9; rep++) begin
      for (int p = 0; p < 7; p++) begin
        g  = gen_next(g);
        c  = (rep == 8 && p == 2);
        lk = (p == 0 || p == 1 || p == 6);
        er = (p == 1 || p == 2);
        if (er) n++;
        if (p == 2) lost = 1'b1;
        if (c) begin
          n = 0;
          lost = 1'b0;
        end
        step(0, 1, c, (p == 0) ? (g ^ 4'b0010) : g, lk, er, lost, n);
      end
    end

    step(0, 0, 0, g, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
